pixel_dispatcher: RTL and testbench
===================================

Name: pixel_dispatcher

Overview:
Parametrised frame-walk engine for the fractal renderer: walks a H_RES x V_RES frame in raster order and issues one pixel per handshake beat, tagged with the solver that owns it. Rows are grouped into chunks of ROWS_PER_CHUNK, and each chunk goes to a free solver chosen round-robin. Sits between the frame controller (start/abort/frame_done) and the solver array (solver_free mask, per-pixel valid/ready stream).

Parameters:
H_RES, 640, pixels per row (>=2)
V_RES, 480, rows per frame (>=1)
NUM_SOLVERS, 4, solver count (1..64)
ROWS_PER_CHUNK, 1, rows per chunk granted to one solver (>=1)
ADDR_W, 19, linear address width; must hold H_RES*V_RES-1
X_W, $clog2(H_RES), column width (derived)
Y_W, $clog2(V_RES), row width (derived)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; begins a frame when idle
abort  in  1  synchronous; drops current frame
solver_free  in  NUM_SOLVERS  bit i=1: solver i can accept a new chunk
out_valid  out  1  pixel beat valid
out_ready  in  1  downstream accepts beat
solver_id  out  6  solver owning current pixel
solver_addr  out  ADDR_W  y*H_RES+x
pix_x  out  X_W  column
pix_y  out  Y_W  row
last_in_chunk  out  1  final pixel of current chunk
last_in_frame  out  1  final pixel of frame
busy  out  1  high in ARB/EMIT/DONE
frame_done  out  1  one-cycle pulse after final beat

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr pointer 0; x/y/addr 0.
- States: IDLE, ARB, EMIT, DONE.
- IDLE: start=1 -> ARB; x,y,addr cleared to 0.
- ARB: search solver_free from rr pointer upward, mod NUM_SOLVERS; first set bit wins. Single-cycle combinational search. On grant: solver_id <= winner; rr <= winner+1 mod NUM_SOLVERS; -> EMIT. No free bit: stay in ARB, out_valid=0.
- solver_free is sampled only in ARB. Changes during EMIT have no effect.
- Latency: start to first out_valid is 2 cycles when a solver is free.
- EMIT: out_valid=1. All outputs hold stable while out_valid & ~out_ready.
- On a handshake, advance: x+1, addr+1. At x=H_RES-1: x<=0, y+1; addr stays contiguous (+1).
- last_in_chunk=1 when x=H_RES-1 and either (row is the final row of the chunk) or y=V_RES-1.
- last_in_frame=1 when x=H_RES-1 and y=V_RES-1.
- Handshake with last_in_chunk & ~last_in_frame -> ARB (out_valid drops for at least 1 cycle).
- Handshake with last_in_frame -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- Short final chunk: if V_RES is not a multiple of ROWS_PER_CHUNK, the final chunk has V_RES mod ROWS_PER_CHUNK rows.
- start outside IDLE: ignored.
- abort in any non-IDLE state: -> IDLE next cycle; out_valid=0; no frame_done. abort wins over start in the same cycle.
- Reset mid-frame: immediate return to reset values.
- NUM_SOLVERS=1: solver 0 only; rr stays 0.

Optional Feature:
PIXEL_DISPATCHER_SERPENTINE_EN
- Defined: rows with odd y are emitted right-to-left (x = H_RES-1 down to 0), with solver_addr decrementing. last flags fire at x=0 on odd rows. At each row change, addr is computed so that addr = y*H_RES+x still holds.
- Undefined: all rows are emitted left-to-right.

Test Plan:
- H_RES=4,V_RES=2,NUM_SOLVERS=1, out_ready=1, start -> out_valid rises 2 cycles after start; addr 0..7; last_in_chunk at addr 3 and 7; last_in_frame at 7; frame_done 1 cycle later; busy low afterwards.
- NUM_SOLVERS=4, solver_free=4'b1111, ROWS_PER_CHUNK=1, V_RES=6 -> solver_id sequence 0,1,2,3,0,1 per row.
- solver_free=4'b0100 from the start -> every chunk goes to solver 2. Drop solver_free to 0 at a chunk boundary -> ARB stalls with out_valid=0; raise bit 1 -> resumes on solver 1.
- out_ready toggles 1,0,0,1 mid-row -> outputs held across the stall; no skipped or duplicated addresses.
- V_RES=5, ROWS_PER_CHUNK=2 -> chunks of 2,2,1 rows; third chunk's last_in_chunk coincides with last_in_frame.
- Assert abort mid-frame -> out_valid=0 next cycle, no frame_done. Assert async reset mid-beat -> all outputs 0 immediately. A new start then restarts at addr 0 with rr pointer 0.

Source files
------------

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks an H_RES x V_RES frame in raster order, handing row chunks to free solvers round-robin.
// Optional build macro PIXEL_DISPATCHER_SERPENTINE_EN emits odd rows right-to-left.
module pixel_dispatcher #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int NUM_SOLVERS    = 4,
    parameter int ROWS_PER_CHUNK = 1,
    parameter int ADDR_W         = 19,
    parameter int X_W            = $clog2(H_RES),
    parameter int Y_W            = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_SOLVERS-1:0] solver_free,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5:0]             solver_id,
    output logic [ADDR_W-1:0]      solver_addr,
    output logic [X_W-1:0]         pix_x,
    output logic [Y_W-1:0]         pix_y,
    output logic                   last_in_chunk,
    output logic                   last_in_frame,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int RR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam int CR_W = (ROWS_PER_CHUNK > 1) ? $clog2(ROWS_PER_CHUNK) : 1;
    localparam logic [X_W-1:0]  X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]  Y_LAST = Y_W'(V_RES - 1);
    localparam logic [CR_W-1:0] C_LAST = CR_W'(ROWS_PER_CHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_r;
    logic [RR_W-1:0]        rr_r;
    logic [CR_W-1:0]        crow_r;

    logic [2*NUM_SOLVERS-1:0] free_rot_s;
    logic                   grant_s;
    logic [RR_W-1:0]        win_s;
    logic [RR_W-1:0]        rr_next_s;

    logic                   row_end_s;
    logic                   nrow_end_s;
    logic [X_W-1:0]         nx_s;
    logic [Y_W-1:0]         ny_s;
    logic [ADDR_W-1:0]      na_s;
    logic [CR_W-1:0]        ncrow_s;
    logic                   nlic_s;
    logic                   nlif_s;

    // Round-robin search: rotate the free mask so the pointer sits at bit 0; lowest set bit wins.
    always_comb begin
        free_rot_s = {solver_free, solver_free} >> rr_r;
        grant_s    = 1'b0;
        win_s      = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            grant_s = grant_s | free_rot_s[i];
            win_s   = free_rot_s[i] ? RR_W'((int'(rr_r) + i) % NUM_SOLVERS) : win_s;
        end
        if (int'(win_s) == NUM_SOLVERS - 1) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = win_s + RR_W'(1);
        end
    end

    // Next raster position and the last-flags that will apply once we move there.
    always_comb begin
`ifdef PIXEL_DISPATCHER_SERPENTINE_EN
        row_end_s = pix_y[0] ? (pix_x == '0) : (pix_x == X_LAST);
`else
        row_end_s = (pix_x == X_LAST);
`endif
        if (row_end_s) begin
            ny_s    = pix_y + Y_W'(1);
            ncrow_s = (crow_r == C_LAST) ? '0 : crow_r + CR_W'(1);
`ifdef PIXEL_DISPATCHER_SERPENTINE_EN
            // Direction flips, so the column repeats and the address jumps one full row.
            nx_s    = pix_x;
            na_s    = solver_addr + ADDR_W'(H_RES);
`else
            nx_s    = '0;
            na_s    = solver_addr + ADDR_W'(1);
`endif
        end else begin
            ny_s    = pix_y;
            ncrow_s = crow_r;
`ifdef PIXEL_DISPATCHER_SERPENTINE_EN
            if (pix_y[0]) begin
                nx_s = pix_x - X_W'(1);
                na_s = solver_addr - ADDR_W'(1);
            end else begin
                nx_s = pix_x + X_W'(1);
                na_s = solver_addr + ADDR_W'(1);
            end
`else
            nx_s    = pix_x + X_W'(1);
            na_s    = solver_addr + ADDR_W'(1);
`endif
        end
`ifdef PIXEL_DISPATCHER_SERPENTINE_EN
        nrow_end_s = ny_s[0] ? (nx_s == '0) : (nx_s == X_LAST);
`else
        nrow_end_s = (nx_s == X_LAST);
`endif
        nlic_s = nrow_end_s & ((ncrow_s == C_LAST) | (ny_s == Y_LAST));
        nlif_s = nrow_end_s & (ny_s == Y_LAST);
    end

    // Frame-walk FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_r          <= '0;
            crow_r        <= '0;
            out_valid     <= 1'b0;
            solver_id     <= 6'd0;
            solver_addr   <= '0;
            pix_x         <= '0;
            pix_y         <= '0;
            last_in_chunk <= 1'b0;
            last_in_frame <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    out_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    if (start && !abort) begin
                        state_r       <= ARB;
                        busy          <= 1'b1;
                        pix_x         <= '0;
                        pix_y         <= '0;
                        solver_addr   <= '0;
                        crow_r        <= '0;
                        last_in_chunk <= 1'b0;
                        last_in_frame <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ARB: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (grant_s) begin
                        state_r   <= EMIT;
                        solver_id <= 6'(win_s);
                        rr_r      <= rr_next_s;
                        out_valid <= 1'b1;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (out_ready) begin
                        if (last_in_frame) begin
                            state_r    <= DONE;
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            pix_x         <= nx_s;
                            pix_y         <= ny_s;
                            solver_addr   <= na_s;
                            crow_r        <= ncrow_s;
                            last_in_chunk <= nlic_s;
                            last_in_frame <= nlif_s;
                            if (last_in_chunk) begin
                                state_r   <= ARB;
                                out_valid <= 1'b0;
                            end else begin
                                out_valid <= 1'b1;
                            end
                        end
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Self-checking bench for pixel_dispatcher: directed vector table, corner sequences and a random
// handshake run compared with a frame-level reference model (H_RES=4, V_RES=5, 4 solvers, 2-row chunks).
module tb_pixel_dispatcher;

    localparam int H   = 4;
    localparam int V   = 5;
    localparam int N   = 4;
    localparam int RPC = 2;
    localparam int AW  = 5;
    localparam int XW  = 2;
    localparam int YW  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [N-1:0]  solver_free;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    solver_id;
    logic [AW-1:0] solver_addr;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          last_in_chunk;
    logic          last_in_frame;
    logic          busy;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int m_rr     = 0;

    always #5 clock = ~clock;

    pixel_dispatcher #(
        .H_RES(H), .V_RES(V), .NUM_SOLVERS(N), .ROWS_PER_CHUNK(RPC), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .solver_free(solver_free), .out_valid(out_valid), .out_ready(out_ready),
        .solver_id(solver_id), .solver_addr(solver_addr), .pix_x(pix_x), .pix_y(pix_y),
        .last_in_chunk(last_in_chunk), .last_in_frame(last_in_frame),
        .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        logic       start;
        logic       abort;
        logic       ready;
        logic [3:0] free;
        logic       valid;
        int         addr;
        int         x;
        int         sid;
        logic       lic;
        logic       lif;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected beat number idx of a frame, straight from the raster/chunk rules.
    task automatic model_beat(input int idx, output int x, output int y, output int addr,
                              output int lic, output int lif, output int first);
        int k;
        y = idx / H;
        k = idx % H;
        x = k;
`ifdef PIXEL_DISPATCHER_SERPENTINE_EN
        if (y % 2 == 1) x = H - 1 - k;
`endif
        addr  = y * H + x;
        lic   = (k == H - 1 && ((y % RPC) == RPC - 1 || y == V - 1)) ? 1 : 0;
        lif   = (k == H - 1 && y == V - 1) ? 1 : 0;
        first = (k == 0 && (y % RPC) == 0) ? 1 : 0;
    endtask

    task automatic pick(input logic [N-1:0] mask, output int w);
        int c;
        w = -1;
        for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (w < 0 && mask[c[1:0]]) w = c;
        end
        if (w >= 0) m_rr = (w + 1) % N;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_rr  = 0;
    endtask

    task automatic run_frame(input int ready_pct, input bit rand_mask);
        int idx = 0, cyc = 0, stage = 0, sid = 0;
        int x, y, a, lic, lif, first;
        bit resolved = 1'b0, gap = 1'b0;
        if (rand_mask) solver_free = N'($urandom_range(1, 15));
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        while (stage < 3 && cyc < 500) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (stage == 1) begin
                check("done_pulse", frame_done, 1);
                check("done_valid", out_valid, 0);
                stage = 2;
            end else if (stage == 2) begin
                check("done_clear", frame_done, 0);
                check("idle_busy", busy, 0);
                stage = 3;
            end else begin
                if (gap) begin
                    check("chunk_gap", out_valid, 0);
                    gap = 1'b0;
                end
                if (out_valid) begin
                    model_beat(idx, x, y, a, lic, lif, first);
                    if (first != 0 && !resolved) begin
                        pick(solver_free, sid);
                        resolved = 1'b1;
                    end
                    check("addr", solver_addr, a);
                    check("pix_x", pix_x, x);
                    check("pix_y", pix_y, y);
                    check("solver_id", solver_id, sid);
                    check("last_in_chunk", last_in_chunk, lic);
                    check("last_in_frame", last_in_frame, lif);
                    check("busy", busy, 1);
                    out_ready = ($urandom_range(0, 99) < ready_pct);
                    if (out_ready) begin
                        if (lif != 0) stage = 1;
                        else if (lic != 0) begin gap = 1'b1; resolved = 1'b0; end
                        idx++;
                    end
                    if (rand_mask) begin
                        solver_free = N'($urandom_range(1, 15));
                        start = ($urandom_range(0, 9) == 0);
                    end
                end else begin
                    out_ready = ($urandom_range(0, 99) < ready_pct);
                end
            end
        end
        if (stage < 3) check("frame_timeout", stage, 3);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; solver_free = '0;

        // start  abort ready free     valid addr x sid lic  lif  busy done
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 2, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, 3, 3, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Directed table: latency, stall hold, abort, abort-over-start.
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; abort = tbl[i].abort;
            out_ready = tbl[i].ready; solver_free = tbl[i].free;
            @(negedge clock);
            check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].valid);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("tbl%0d_done", i), frame_done, tbl[i].done);
            if (tbl[i].valid || i == 0) begin
                check($sformatf("tbl%0d_addr", i), solver_addr, tbl[i].addr);
                check($sformatf("tbl%0d_x", i), pix_x, tbl[i].x);
                check($sformatf("tbl%0d_sid", i), solver_id, tbl[i].sid);
                check($sformatf("tbl%0d_lic", i), last_in_chunk, tbl[i].lic);
                check($sformatf("tbl%0d_lif", i), last_in_frame, tbl[i].lif);
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0; abort = 1'b0;

        // Free mask empties at a chunk boundary: arbitration stalls, then resumes on solver 1.
        do_reset();
        solver_free = 4'b0100; out_ready = 1'b1;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clock);
            if (out_valid && last_in_chunk) begin
                solver_free = '0;
                found = 1'b1;
            end
        end
        check("boundary_reached", found, 1);
        repeat (4) begin
            @(negedge clock);
            check("stall_valid", out_valid, 0);
            check("stall_busy", busy, 1);
        end
        solver_free = 4'b0010;
        @(negedge clock);
        check("resume_valid", out_valid, 1);
        check("resume_sid", solver_id, 1);
        check("resume_addr", solver_addr, 8);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clock);
        check("abort_no_done", frame_done, 0);

        // Asynchronous reset in the middle of a beat.
        solver_free = 4'b1111; out_ready = 1'b1;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (4) @(negedge clock);
        check("pre_reset_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_addr", solver_addr, 0);
        check("rst_sid", solver_id, 0);
        check("rst_xy", {pix_x, pix_y}, 0);
        check("rst_flags", {last_in_chunk, last_in_frame, busy, frame_done}, 0);
        @(negedge clock);
        reset = 1'b0;
        m_rr = 0;
        out_ready = 1'b0;

        // Full frame, all solvers free, no backpressure: chunks go to 0,1,2.
        run_frame(100, 1'b0);

        // Random backpressure, random free masks, stray start pulses mid-frame.
        for (int f = 0; f < 6; f++) run_frame(70, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
